fmul_issue: RTL
===============

Name: fmul_issue

Overview:
- Issue/collect stage wrapped around the existing one-register-stage fmul core. The core is instantiated by the FPU top level, not inside this block.
- Accepts operand pairs from decode over a valid/ready handshake and drives the fmul operand inputs.
- Holds the operands stable for the core's two-cycle evaluation window. The core samples partial products at one edge, and its sign/exponent path reads the operands combinationally in the following cycle.
- Captures the product with its destination tag and presents it to writeback over a second valid/ready handshake.

Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside each operation.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstn  in  1  synchronous active-low reset, sampled on posedge clk.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- in_a  in  32  IEEE-754 single operand 1.
- in_b  in  32  IEEE-754 single operand 2.
- in_tag  in  TAG_W  destination tag.
- mul_x1  out  32  to fmul x1; registered.
- mul_x2  out  32  to fmul x2; registered.
- mul_y  in  32  from fmul y.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback consumes the result.
- out_y  out  32  product.
- out_tag  out  TAG_W  tag of the product.

Behaviour:
- Reset (rstn=0 at posedge):
  - State returns to IDLE.
  - mul_x1, mul_x2, out_y and out_tag clear to 0; out_valid clears to 0.
  - in_ready is forced to 0 while rstn=0.
- FSM states: IDLE, LOAD, EVAL. Only the state register and the output slot are sequential control.
- IDLE:
  - in_ready = slot_free, where slot_free = !out_valid || out_ready.
  - On in_valid && in_ready: latch in_a→mul_x1, in_b→mul_x2 and in_tag→op_tag, then go to LOAD.
  - With no accept, stay in IDLE; mul_x1/mul_x2 hold their last values.
- LOAD: in_ready=0. mul_x1/mul_x2 are stable, and fmul registers its partial products at the end of this cycle. Next state is EVAL.
- EVAL:
  - in_ready=0. mul_x1/mul_x2 are still held, so mul_y is valid.
  - At the end of the cycle, write mul_y→out_y and op_tag→out_tag, set out_valid=1, and go to IDLE.
- mul_x1/mul_x2 must not change in LOAD or EVAL.
- Output slot:
  - out_valid clears on out_valid && out_ready unless an EVAL write happens in the same cycle; the write wins.
  - out_y/out_tag hold while out_valid && !out_ready.
  - Accepting only when slot_free guarantees the EVAL write never overwrites an unconsumed result.
- Timing:
  - Latency: accept at edge N → out_valid=1 after edge N+2.
  - Throughput: one op per 3 cycles with no backpressure.
- Arithmetic: none in this block. Values pass through unmodified, including zero/denormal flush and sign handling done by the core.
- Reset mid-operation (in LOAD or EVAL) discards the operation; no result is ever presented.
- If in_valid arrives while in LOAD/EVAL, it is not accepted, and decode holds it.

Optional Feature:
- Macro: FMUL_ISSUE_FIFO_EN.
- Defined:
  - The single output slot is replaced by a 2-entry FIFO (count 0..2, wrap-around read/write pointers).
  - slot_free = (count<2) || out_ready.
  - EVAL pushes a result, and out_valid && out_ready pops one. Simultaneous push and pop leaves count unchanged.
  - out_valid = (count!=0); out_y/out_tag present the head entry.
  - Reset clears count and both pointers.
- Undefined: the single-slot behaviour above.

Test Plan:
- Basic: rstn=1, out_ready=1, in_a=0x40000000, in_b=0x40400000, in_tag=3 → out_valid=1 two edges after accept with out_y=0x40C00000, out_tag=3.
- Sign: in_a=0x3FC00000, in_b=0xC0000000 → out_y=0xC0400000.
- Zero operand: in_a=0x80000000, in_b=0x3F800000 → out_y=0x80000000.
- Backpressure:
  - Hold out_ready=0 after the first result (tag 1) and present a second op (tag 2).
  - Required: in_ready=0, out_y/out_tag stable at tag 1.
  - Raise out_ready for one cycle → tag 1 consumed and op 2 accepted the same cycle; tag 2 appears 2 edges later.
- Reset mid-op: accept an op, drop rstn in LOAD → out_valid stays 0, state IDLE, and no late result after rstn rises.
- FIFO (FMUL_ISSUE_FIFO_EN):
  - With out_ready=0, issue tags 1,2 → both accepted; in_ready=0 once count=2.
  - Drain → out_tag 1 then 2, each exactly once.

Source files
------------

// File: rtl/fmul_issue.sv
// Issue/collect stage around the external one-register-stage fmul core: holds operands for the
// core's two-cycle window and queues tagged products for writeback. `FMUL_ISSUE_FIFO_EN selects a 2-entry output FIFO.
module fmul_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_x1,
    output logic [31:0]      mul_x2,
    input  logic [31:0]      mul_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EVAL = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_x1;
    logic [31:0]      r_x2;
    logic [TAG_W-1:0] r_op_tag;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    assign mul_x1   = r_x1;
    assign mul_x2   = r_x2;
    assign w_accept = in_valid && in_ready;
    assign w_push   = (r_state == S_EVAL);
    assign w_pop    = out_valid && out_ready;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = rstn && w_slot_free;
                if (in_valid && in_ready) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD:  w_state_nxt = S_EVAL;
            S_EVAL:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_x1     <= '0;
            r_x2     <= '0;
            r_op_tag <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_x1     <= in_a;
                r_x2     <= in_b;
                r_op_tag <= in_tag;
            end
        end
    end

`ifdef FMUL_ISSUE_FIFO_EN
    logic [31:0]      r_fifo_y   [2];
    logic [TAG_W-1:0] r_fifo_tag [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    assign w_slot_free = (r_count < 2'd2) || out_ready;
    assign out_valid   = (r_count != 2'd0);
    assign out_y       = r_fifo_y[r_rd_ptr];
    assign out_tag     = r_fifo_tag[r_rd_ptr];

    // NOTE: the two entries are cleared on reset so out_y/out_tag read 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_y[i]   <= '0;
                r_fifo_tag[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_y[r_wr_ptr]   <= mul_y;
                r_fifo_tag[r_wr_ptr] <= r_op_tag;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic             r_out_valid;
    logic [31:0]      r_out_y;
    logic [TAG_W-1:0] r_out_tag;

    assign w_slot_free = !r_out_valid || out_ready;
    assign out_valid   = r_out_valid;
    assign out_y       = r_out_y;
    assign out_tag     = r_out_tag;

    // An EVAL write takes priority over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_tag   <= '0;
        end else if (w_push) begin
            r_out_valid <= 1'b1;
            r_out_y     <= mul_y;
            r_out_tag   <= r_op_tag;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

endmodule
